// File: rtl/uart_echo_responder_if.sv
// Serial line and status bundle for the UART echo responder.
// master = link tester side, slave = responder.
interface uart_echo_responder_if;
  logic       rx;
  logic       tx_en;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  modport master (
    output rx, tx_en,
    input  tx, rx_data, rx_ready,
    input  frame_err, overflow, busy
  );

  modport slave (
    input  rx, tx_en,
    output tx, rx_data, rx_ready,
    output frame_err, overflow, busy
  );
endinterface

// File: rtl/uart_echo_responder.sv
// Far-end UART node: receives 8N1 bytes, queues them and
// echoes each one (XOR-masked) back on tx.
module uart_echo_responder #(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 115200,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ECHO_XOR   = 8'h00
) (
  input logic clk,
  input logic rst,
  uart_echo_responder_if.slave io
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_state_t;

  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;

  logic          rx_meta, rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_tick, rx_good, rx_bad, rx_cnt_clr;
  logic [7:0]    rx_data_q;
  logic          rx_ready_q, frame_err_q, overflow_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push_ok;
  logic [7:0]    head;

  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_q;
  logic          tx_go, tx_pop, tx_tick;
  logic          tx_shift, tx_mark;

  // rx is asynchronous; sync flops idle high so reset never looks like a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= io.rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_q <= R_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      R_IDLE:
        if (!rx_sync) rx_state_d = R_START;
      R_START:
        if (rx_cnt == HALF)
          rx_state_d = rx_sync ? R_IDLE : R_DATA;
      R_DATA:
        if (rx_cnt == LAST && rx_bit == 3'd7)
          rx_state_d = R_STOP;
      R_STOP:
        if (rx_cnt == LAST)
          rx_state_d = rx_sync ? R_IDLE : R_WAIT;
      R_WAIT:
        if (rx_sync) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_tick    = 1'b0;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    rx_cnt_clr = 1'b0;
    if (rx_cnt == LAST) begin
      rx_tick = (rx_state_q == R_DATA);
      rx_good = (rx_state_q == R_STOP) && rx_sync;
      rx_bad  = (rx_state_q == R_STOP) && !rx_sync;
    end
    rx_cnt_clr = rx_tick || (rx_state_d != rx_state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_sh       <= '0;
      rx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
      if (rx_state_q != R_DATA) rx_bit <= '0;
      else if (rx_tick)         rx_bit <= rx_bit + 3'd1;
      if (rx_tick) rx_sh <= {rx_sync, rx_sh[7:1]};
      if (rx_good) rx_data_q <= rx_sh;
      rx_ready_q  <= rx_good;
      frame_err_q <= rx_bad;
      overflow_q  <= rx_good && !push_ok;
    end
  end

  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = rx_good && (!fifo_full || tx_pop);
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign tx_go   = io.tx_en && !fifo_empty;
  assign tx_tick = (tx_state_q != T_IDLE) && (tx_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_q <= T_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      T_IDLE:
        if (tx_go) tx_state_d = T_START;
      T_START:
        if (tx_tick) tx_state_d = T_DATA;
      T_DATA:
        if (tx_tick && tx_bit == 3'd7)
          tx_state_d = T_STOP;
      T_STOP:
        if (tx_tick)
          tx_state_d = tx_go ? T_START : T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // the end of a stop bit may chain straight into the next start bit
  always_comb begin
    tx_pop   = 1'b0;
    tx_shift = 1'b0;
    tx_mark  = 1'b0;
    unique case (tx_state_q)
      T_IDLE:  tx_pop   = tx_go;
      T_START: tx_shift = tx_tick;
      T_DATA: begin
        tx_shift = tx_tick && (tx_bit != 3'd7);
        tx_mark  = tx_tick && (tx_bit == 3'd7);
      end
      T_STOP:  tx_pop   = tx_tick && tx_go;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_cnt <= (tx_pop || tx_tick) ? '0 : tx_cnt + 1'b1;
      unique case (1'b1)
        tx_pop: begin
          tx_sh  <= head ^ ECHO_XOR;
          tx_bit <= '0;
          tx_q   <= 1'b0;
        end
        tx_shift: begin
          tx_q  <= tx_sh[0];
          tx_sh <= {1'b0, tx_sh[7:1]};
          if (tx_state_q == T_DATA)
            tx_bit <= tx_bit + 3'd1;
        end
        tx_mark: tx_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign io.tx        = tx_q;
  assign io.rx_data   = rx_data_q;
  assign io.rx_ready  = rx_ready_q;
  assign io.frame_err = frame_err_q;
  assign io.overflow  = overflow_q;
  assign io.busy      = (rx_state_q != R_IDLE) ||
                        (tx_state_q != T_IDLE) ||
                        !fifo_empty;

endmodule
